// File: rtl/vidmeas_pkg.sv
// Shared video-measurement types and the VGA/XGA timing constants used by the pattern generator.
package vidmeas_pkg;

    localparam int unsigned VGA_H_TOTAL  = 800;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_V_TOTAL  = 525;
    localparam int unsigned VGA_V_ACTIVE = 480;

    localparam int unsigned XGA_H_TOTAL  = 1344;
    localparam int unsigned XGA_H_ACTIVE = 1024;
    localparam int unsigned XGA_V_TOTAL  = 806;
    localparam int unsigned XGA_V_ACTIVE = 768;

    typedef enum logic [1:0] {
        MODE_NONE  = 2'b00,
        MODE_VGA   = 2'b01,
        MODE_XGA   = 2'b10,
        MODE_OTHER = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10
    } fsm_t;

    // Classify a locked timing tuple; callers gate with lock state.
    function automatic mode_t classify(input int unsigned ht, input int unsigned ha,
                                       input int unsigned vt, input int unsigned va);
        if (ht == VGA_H_TOTAL && ha == VGA_H_ACTIVE && vt == VGA_V_TOTAL && va == VGA_V_ACTIVE)
            return MODE_VGA;
        if (ht == XGA_H_TOTAL && ha == XGA_H_ACTIVE && vt == XGA_V_TOTAL && va == XGA_V_ACTIVE)
            return MODE_XGA;
        return MODE_OTHER;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-stage input register with a registered falling-edge pulse; o_lvl is aligned with o_fall.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= RST_VAL;
            r_s2   <= RST_VAL;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_d;
            r_s2   <= r_s1;
            r_fall <= r_s2 & ~r_s1;
        end
    end

    assign o_lvl  = r_s2;
    assign o_fall = r_fall;

endmodule

// File: rtl/vid_timing_meas.sv
// Display-stream timing checker: measures line/frame geometry and pixel checksum, locks and classifies the mode.
import vidmeas_pkg::*;

module vid_timing_meas #(
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_x,
    input  logic             vsync_x,
    input  logic             de,
    input  logic [7:0]       r,
    input  logic [7:0]       g,
    input  logic [7:0]       b,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [15:0]      frame_sum,
    output logic             meas_valid,
    output logic             locked,
    output logic [1:0]       mode,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned MC_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic w_h_fall, w_v_fall, w_de;
    logic w_hs_unused, w_vs_unused, w_de_fall_unused;

    sync_edge_det #(.RST_VAL(1'b1)) u_hs (.clk(clk), .rst(rst), .i_d(hsync_x), .o_lvl(w_hs_unused), .o_fall(w_h_fall));
    sync_edge_det #(.RST_VAL(1'b1)) u_vs (.clk(clk), .rst(rst), .i_d(vsync_x), .o_lvl(w_vs_unused), .o_fall(w_v_fall));
    sync_edge_det #(.RST_VAL(1'b0)) u_de (.clk(clk), .rst(rst), .i_d(de), .o_lvl(w_de), .o_fall(w_de_fall_unused));

    // Pixel path: two stages so the per-cycle r+g+b lines up with the delayed de.
    logic [23:0] r_px_s1;
    logic [9:0]  r_px_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px_s1  <= '0;
            r_px_sum <= '0;
        end else begin
            r_px_s1  <= {r, g, b};
            r_px_sum <= 10'(r_px_s1[23:16]) + 10'(r_px_s1[15:8]) + 10'(r_px_s1[7:0]);
        end
    end

    logic [CNT_W-1:0] r_h_cnt, r_de_cnt, r_v_cnt, r_v_act, r_sh_htot, r_sh_hact;
    logic [15:0]      r_sum;
    logic             r_ovf, r_armed;
    fsm_t             r_state;
    logic [MC_W-1:0]  r_match_cnt;

    logic [CNT_W-1:0] w_htot_nxt, w_hact_nxt, w_vact_nxt;
    logic             w_line_de, w_ovf_evt, w_match;
    logic [15:0]      w_sum_nxt;
    mode_t            w_mode;

    // Frame-end values include the line closed by an hsync fall coincident with vsync.
    always_comb begin
        w_line_de  = (r_de_cnt != '0);
        w_htot_nxt = w_h_fall ? r_h_cnt : r_sh_htot;
        w_hact_nxt = (w_h_fall && w_line_de) ? r_de_cnt : r_sh_hact;
        w_vact_nxt = r_v_act;
        if (w_h_fall && w_line_de && (r_v_act != CNT_MAX))
            w_vact_nxt = r_v_act + CNT_W'(1);
        w_ovf_evt  = (!w_h_fall && (r_h_cnt == CNT_MAX))
                   || (!w_h_fall && w_de && (r_de_cnt == CNT_MAX))
                   || (w_h_fall && !w_v_fall && (r_v_cnt == CNT_MAX))
                   || (w_h_fall && w_line_de && (r_v_act == CNT_MAX));
        w_match    = (w_htot_nxt == h_total) && (w_hact_nxt == h_active)
                   && (r_v_cnt == v_total) && (w_vact_nxt == v_active);
        w_mode     = classify(32'(w_htot_nxt), 32'(w_hact_nxt), 32'(r_v_cnt), 32'(w_vact_nxt));
        w_sum_nxt  = r_sum + 16'(r_px_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt     <= '0;
            r_de_cnt    <= '0;
            r_v_cnt     <= '0;
            r_v_act     <= '0;
            r_sh_htot   <= '0;
            r_sh_hact   <= '0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_armed     <= 1'b0;
            r_state     <= SEARCH;
            r_match_cnt <= '0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            frame_sum   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            mode        <= MODE_NONE;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            meas_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (w_h_fall) begin
                r_h_cnt   <= CNT_W'(1);
                r_sh_htot <= r_h_cnt;
                r_de_cnt  <= CNT_W'(w_de);
                if (w_line_de)
                    r_sh_hact <= r_de_cnt;
            end else begin
                if (r_h_cnt != CNT_MAX)
                    r_h_cnt <= r_h_cnt + CNT_W'(1);
                if (w_de && (r_de_cnt != CNT_MAX))
                    r_de_cnt <= r_de_cnt + CNT_W'(1);
            end

            if (w_v_fall) begin
                r_v_cnt <= CNT_W'(w_h_fall);
                r_v_act <= '0;
                r_sum   <= w_de ? 16'(r_px_sum) : 16'd0;
                r_ovf   <= 1'b0;
                r_armed <= 1'b1;
                if (r_armed) begin
                    h_total    <= w_htot_nxt;
                    h_active   <= w_hact_nxt;
                    v_total    <= r_v_cnt;
                    v_active   <= w_vact_nxt;
                    frame_sum  <= r_sum;
                    meas_valid <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                    if (r_ovf || w_ovf_evt) begin
                        r_state     <= SEARCH;
                        r_match_cnt <= '0;
                        locked      <= 1'b0;
                        mode        <= MODE_NONE;
                        frame_err   <= 1'b1;
                    end else begin
                        case (r_state)
                            SEARCH: begin
                                r_state     <= TRACK;
                                r_match_cnt <= MC_W'(1);
                            end
                            TRACK: begin
                                if (!w_match) begin
                                    r_match_cnt <= MC_W'(1);
                                end else begin
                                    r_match_cnt <= r_match_cnt + MC_W'(1);
                                    if ((r_match_cnt + MC_W'(1)) >= MC_W'(LOCK_FRAMES)) begin
                                        r_state <= LOCKED;
                                        locked  <= 1'b1;
                                        mode    <= w_mode;
                                    end
                                end
                            end
                            LOCKED: begin
                                if (!w_match) begin
                                    r_state     <= TRACK;
                                    r_match_cnt <= MC_W'(1);
                                    locked      <= 1'b0;
                                    mode        <= MODE_NONE;
                                    frame_err   <= 1'b1;
                                end
                            end
                            default: r_state <= SEARCH;
                        endcase
                    end
                end
            end else begin
                if (w_h_fall && (r_v_cnt != CNT_MAX))
                    r_v_cnt <= r_v_cnt + CNT_W'(1);
                r_v_act <= w_vact_nxt;
                if (w_de)
                    r_sum <= w_sum_nxt;
                if (w_ovf_evt)
                    r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vid_timing_meas.sv
// Scoreboard bench: frame generator pushes expected measurements, a negedge monitor checks each meas_valid.
module tb_vid_timing_meas;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync_x, vsync_x, de;
    logic [7:0]  r, g, b;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic [15:0] frame_sum, frame_cnt;
    logic        meas_valid, locked, frame_err;
    logic [1:0]  mode;

    vid_timing_meas #(.CNT_W(12), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .hsync_x(hsync_x), .vsync_x(vsync_x), .de(de),
        .r(r), .g(g), .b(b),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .frame_sum(frame_sum), .meas_valid(meas_valid), .locked(locked), .mode(mode),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] ht, ha, vt, va;
        logic [15:0] sum;
        logic        lk;
        logic [1:0]  md;
        logic        err;
        logic [15:0] fc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_pass = 0;
    int          fcnt = 0;
    logic [15:0] acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every measurement must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && meas_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_meas_valid: got meas_valid=1 expected none at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                chk("h_total",   32'(h_total),   32'(mon_e.ht));
                chk("h_active",  32'(h_active),  32'(mon_e.ha));
                chk("v_total",   32'(v_total),   32'(mon_e.vt));
                chk("v_active",  32'(v_active),  32'(mon_e.va));
                chk("frame_sum", 32'(frame_sum), 32'(mon_e.sum));
                chk("locked",    32'(locked),    32'(mon_e.lk));
                chk("mode",      32'(mode),      32'(mon_e.md));
                chk("frame_err", 32'(frame_err), 32'(mon_e.err));
                chk("frame_cnt", 32'(frame_cnt), 32'(mon_e.fc));
            end
        end else if (!rst && frame_err) begin
            n_chk++;
            $display("FAIL stray_frame_err: got frame_err=1 without meas_valid at %0t", $time);
        end
    end

    task automatic cyc(input logic hs, input logic vs, input logic d,
                       input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
        @(negedge clk);
        hsync_x = hs; vsync_x = vs; de = d; r = pr; g = pg; b = pb;
        if (d) acc = acc + 16'(pr) + 16'(pg) + 16'(pb);
    endtask

    // Compressed frame: short 2-cycle lines except the last active line and the last line, which
    // carry the full geometry; stretch>0 lengthens the last line so the line counter saturates.
    task automatic frame(input int ht, input int ha, input int vt, input int va, input int stretch,
                         input bit solid, input logic [7:0] pix,
                         input bit lk, input logic [1:0] md, input bit err);
        int   vs, hst, len;
        bit   full, act;
        logic d;
        exp_t x;
        vs  = vt - va - 4;
        hst = ht - ha - 16;
        acc = 16'd0;
        for (int l = 0; l < vt; l++) begin
            full = (l == vs + va - 1) || (l == vt - 1);
            act  = (l >= vs) && (l < vs + va);
            len  = !full ? 2 : ((l == vt - 1) && (stretch > 0)) ? stretch : ht;
            for (int p = 0; p < len; p++) begin
                if (full) d = act && (p >= hst) && (p < hst + ha);
                else      d = act && (p == 1);
                cyc(full ? (p >= 96) : (p != 0), !(l < 2), d,
                    pix, solid ? pix : 8'(l), solid ? pix : 8'(p));
            end
        end
        fcnt++;
        x.ht  = (stretch > 0) ? 12'd4095 : 12'(ht);
        x.ha  = 12'(ha);
        x.vt  = 12'(vt);
        x.va  = 12'(va);
        x.sum = acc;
        x.lk  = lk;
        x.md  = md;
        x.err = err;
        x.fc  = 16'(fcnt);
        q.push_back(x);
    endtask

    // Short lines only, optionally opening with a vsync pulse.
    task automatic partial(input int n, input bit with_vs);
        for (int l = 0; l < n; l++) begin
            cyc(1'b0, !(with_vs && l < 2), 1'b0, 8'd0, 8'd0, 8'd0);
            cyc(1'b1, !(with_vs && l < 2), 1'b0, 8'd0, 8'd0, 8'd0);
        end
    endtask

    task automatic close_frame();
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL %s_drain: got %0d pending measurements expected 0", tag, q.size());
            q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_h_total"},    32'(h_total),    32'd0);
        chk({tag, "_h_active"},   32'(h_active),   32'd0);
        chk({tag, "_v_total"},    32'(v_total),    32'd0);
        chk({tag, "_v_active"},   32'(v_active),   32'd0);
        chk({tag, "_frame_sum"},  32'(frame_sum),  32'd0);
        chk({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
        chk({tag, "_mode"},       32'(mode),       32'd0);
        chk({tag, "_frame_err"},  32'(frame_err),  32'd0);
        chk({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; hsync_x = 1'b1; vsync_x = 1'b1; de = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fcnt = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; hsync_x = 1'b1; vsync_x = 1'b1; de = 1'b0;
        r = 8'd0; g = 8'd0; b = 8'd0; acc = 16'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // VGA lock, solid frame, switch to XGA, overflow recovery.
        frame(800, 640, 525, 480, 0, 1'b0, 8'h10, 1'b0, 2'b00, 1'b0);
        frame(800, 640, 525, 480, 0, 1'b0, 8'h20, 1'b1, 2'b01, 1'b0);
        frame(800, 640, 525, 480, 0, 1'b0, 8'hF0, 1'b1, 2'b01, 1'b0);
        frame(800, 640, 525, 480, 0, 1'b1, 8'h01, 1'b1, 2'b01, 1'b0);
        frame(1344, 1024, 806, 768, 0, 1'b0, 8'h33, 1'b0, 2'b00, 1'b1);
        frame(1344, 1024, 806, 768, 0, 1'b1, 8'hFF, 1'b1, 2'b10, 1'b0);
        frame(800, 640, 525, 480, 0, 1'b0, 8'h44, 1'b0, 2'b00, 1'b1);
        frame(800, 640, 525, 480, 5096, 1'b0, 8'h55, 1'b0, 2'b00, 1'b1);
        frame(800, 640, 525, 480, 0, 1'b0, 8'h66, 1'b0, 2'b00, 1'b0);
        frame(800, 640, 525, 480, 0, 1'b0, 8'h77, 1'b1, 2'b01, 1'b0);
        close_frame();
        wait_drain("vga_xga");

        // XGA from reset, then reset in the middle of a frame.
        reset_dut();
        frame(1344, 1024, 806, 768, 0, 1'b0, 8'h12, 1'b0, 2'b00, 1'b0);
        frame(1344, 1024, 806, 768, 0, 1'b0, 8'h34, 1'b1, 2'b10, 1'b0);
        partial(20, 1'b1);
        wait_drain("xga");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        fcnt = 0;
        partial(10, 1'b0);
        frame(800, 640, 525, 480, 0, 1'b0, 8'h5A, 1'b0, 2'b00, 1'b0);
        close_frame();
        wait_drain("rearm");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
